cic_decimator: RTL and testbench



---
 rtl/cic_decimator_if.sv | 34 +++
 rtl/cic_decimator.sv | 162 ++++++++++++++++
 tb/tb_cic_decimator.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/cic_decimator_if.sv
// cic_decimator_if
//   Bundles the sample stream into and out of cic_decimator.
//   master: drives valid_in, bypass, dec_sel, cic_in; observes cic_out, valid_out, busy.
//   slave : the decimator side (mirror of master).
//   Signals:
//     valid_in  - cic_in carries a sample this cycle
//     bypass    - registered passthrough of cic_in/valid_in
//     dec_sel   - decimation select, R = 2^dec_sel (clamped inside the block)
//     cic_in    - signed Q1.15 input sample
//     cic_out   - signed Q1.15 decimated sample, held between strobes
//     valid_out - one-cycle strobe per output sample
//     busy      - high during the single flush cycle after a rate change
interface cic_decimator_if #(
  parameter int DATA_WIDTH    = 16,
  parameter int DEC_SEL_WIDTH = 3
);
  logic                          valid_in;
  logic                          bypass;
  logic [DEC_SEL_WIDTH-1:0]      dec_sel;
  logic signed [DATA_WIDTH-1:0]  cic_in;
  logic signed [DATA_WIDTH-1:0]  cic_out;
  logic                          valid_out;
  logic                          busy;

  modport master (
    output valid_in, bypass, dec_sel, cic_in,
    input  cic_out, valid_out, busy
  );

  modport slave (
    input  valid_in, bypass, dec_sel, cic_in,
    output cic_out, valid_out, busy
  );
endinterface

// File: rtl/cic_decimator.sv
// cic_decimator
//   Runtime-configurable N-stage CIC decimator, R = 2^dec_sel, with the CIC
//   gain 2^(N*dec_sel) removed by a round-half-up arithmetic shift.
//   Ports:
//     clk - rising-edge clock
//     rst - synchronous, active-high reset
//     cic - cic_decimator_if.slave (valid_in, bypass, dec_sel, cic_in in;
//           cic_out, valid_out, busy out)
//   A change of the clamped dec_sel drops the current sample and spends one
//   FLUSH cycle clearing the filter, after which decimation restarts from
//   zero state at phase 0.
module cic_decimator #(
  parameter int DATA_WIDTH = 16,
  parameter int DATA_FRAC  = 15,
  parameter int NUM_STAGES = 3,
  parameter int MAX_DEC    = 16
) (
  input  logic            clk,
  input  logic            rst,
  cic_decimator_if.slave  cic
);
  localparam int DEC_SEL_MAX   = $clog2(MAX_DEC);
  localparam int DEC_SEL_WIDTH = $clog2(DEC_SEL_MAX + 1);
  localparam int ACC_WIDTH     = DATA_WIDTH + NUM_STAGES * DEC_SEL_MAX;
  localparam int SHIFT_WIDTH   = $clog2(NUM_STAGES * DEC_SEL_MAX + 1);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  if (MAX_DEC < 2 || (MAX_DEC & (MAX_DEC - 1)) != 0 || DATA_FRAC >= DATA_WIDTH) begin : g_param_check
    $error("cic_decimator: MAX_DEC must be a power of two >= 2 and DATA_FRAC < DATA_WIDTH");
  end

  logic [0:0]                   state_reg;
  logic [DEC_SEL_MAX-1:0]       phase_reg;
  logic [DEC_SEL_WIDTH-1:0]     dec_sel_q_reg;
  logic signed [DATA_WIDTH-1:0] cic_out_reg;
  logic                         valid_out_reg;

  logic [DEC_SEL_WIDTH-1:0]     dec_sel_clamp;
  logic [DEC_SEL_MAX-1:0]       phase_max;
  logic                         in_run;
  logic                         rate_change;
  logic                         accept;
  logic                         capture;
  logic                         clear_state;
  logic signed [ACC_WIDTH-1:0]  in_ext;

  assign dec_sel_clamp = (cic.dec_sel > DEC_SEL_WIDTH'(DEC_SEL_MAX))
                         ? DEC_SEL_WIDTH'(DEC_SEL_MAX) : cic.dec_sel;
  assign in_run      = (state_reg == ST_RUN);
  assign rate_change = in_run && !cic.bypass && (dec_sel_clamp != dec_sel_q_reg);
  assign accept      = in_run && !cic.bypass && !rate_change && cic.valid_in;
  assign capture     = accept && (phase_reg == phase_max);
  // Reset, bypass and FLUSH all hold the filter at zero state / phase 0.
  assign clear_state = rst || cic.bypass || (state_reg == ST_FLUSH);
  assign in_ext      = {{(ACC_WIDTH - DATA_WIDTH){cic.cic_in[DATA_WIDTH-1]}}, cic.cic_in};

  // R-1 = 2^dec_sel_q - 1: a mask of dec_sel_q ones.
  for (genvar gi = 0; gi < DEC_SEL_MAX; gi++) begin : g_phase_max
    assign phase_max[gi] = (dec_sel_q_reg > DEC_SEL_WIDTH'(gi));
  end

  // Non-pipelined integrator chain: each stage adds the freshly updated
  // output of the stage before it. Wrap-around is intentional.
  for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_int
    logic signed [ACC_WIDTH-1:0] integ_reg;
    logic signed [ACC_WIDTH-1:0] upd;
    if (gi == 0) begin : g_first
      assign upd = integ_reg + in_ext;
    end else begin : g_rest
      assign upd = integ_reg + g_int[gi-1].upd;
    end
    always_ff @(posedge clk) begin
      if (clear_state) begin
        integ_reg <= '0;
      end else if (accept) begin
        integ_reg <= upd;
      end
    end
  end

  // Comb chain at the decimated rate; each delay loads its own stage input.
  for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_comb
    logic signed [ACC_WIDTH-1:0] comb_dly_reg;
    logic signed [ACC_WIDTH-1:0] din;
    logic signed [ACC_WIDTH-1:0] dout;
    if (gi == 0) begin : g_first
      assign din = g_int[NUM_STAGES-1].upd;
    end else begin : g_rest
      assign din = g_comb[gi-1].dout;
    end
    assign dout = din - comb_dly_reg;
    always_ff @(posedge clk) begin
      if (clear_state) begin
        comb_dly_reg <= '0;
      end else if (capture) begin
        comb_dly_reg <= din;
      end
    end
  end

  // Gain normalisation: add half an LSB of the result, then shift right.
  logic [SHIFT_WIDTH-1:0]       shift_amt;
  logic signed [ACC_WIDTH-1:0]  round_bias;
  logic signed [ACC_WIDTH-1:0]  rounded;
  logic signed [ACC_WIDTH-1:0]  scaled;
  logic signed [DATA_WIDTH-1:0] norm;
  logic                         unused_scaled_hi;

  assign shift_amt  = SHIFT_WIDTH'(NUM_STAGES * int'(dec_sel_q_reg));
  assign round_bias = (shift_amt == '0) ? '0
                      : (ACC_WIDTH'(1) << (shift_amt - SHIFT_WIDTH'(1)));
  assign rounded    = g_comb[NUM_STAGES-1].dout + round_bias;
  assign scaled     = rounded >>> shift_amt;
  // All CIC taps are positive, so the normalised value always fits DATA_WIDTH.
  assign norm       = scaled[DATA_WIDTH-1:0];
  assign unused_scaled_hi = ^scaled[ACC_WIDTH-1:DATA_WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_RUN;
    end else if (state_reg == ST_FLUSH) begin
      state_reg <= ST_RUN;
    end else if (rate_change) begin
      state_reg <= ST_FLUSH;
    end
  end

  always_ff @(posedge clk) begin
    if (clear_state) begin
      phase_reg <= '0;
    end else if (accept) begin
      phase_reg <= capture ? '0 : (phase_reg + DEC_SEL_MAX'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (clear_state) begin
      dec_sel_q_reg <= dec_sel_clamp;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cic_out_reg   <= '0;
      valid_out_reg <= 1'b0;
    end else if (cic.bypass) begin
      cic_out_reg   <= cic.cic_in;
      valid_out_reg <= cic.valid_in;
    end else if (capture) begin
      cic_out_reg   <= norm;
      valid_out_reg <= 1'b1;
    end else begin
      valid_out_reg <= 1'b0;
    end
  end

  assign cic.cic_out   = cic_out_reg;
  assign cic.valid_out = valid_out_reg;
  assign cic.busy      = (state_reg == ST_FLUSH);
endmodule

// File: tb/tb_cic_decimator.sv
// tb_cic_decimator
//   Directed bench for cic_decimator (N=3, MAX_DEC=16). Expected outputs come
//   from a direct-form reference: the CIC impulse response is built by
//   convolving N boxcars of length R, applied to the accepted-sample history
//   since the last zero state, then rounded half-up and shifted by N*dec_sel.
//   Note the filter starts from zero state, so a DC input only reaches its
//   final value after N decimated outputs (e.g. 0x4000 -> 0x1400, 0x3C00, 0x4000).
module tb_cic_decimator;
  localparam int N = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cic_decimator_if #(.DATA_WIDTH(16), .DEC_SEL_WIDTH(3)) bus ();

  cic_decimator #(
    .DATA_WIDTH(16), .DATA_FRAC(15), .NUM_STAGES(N), .MAX_DEC(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cic(bus)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  longint      hist[$];
  logic [15:0] exp_q[$];
  logic [15:0] m_out;
  logic [2:0]  m_dec;
  logic        m_flush;

  function automatic logic [15:0] cic_ref(input int sel);
    longint      h [64];
    longint      t [64];
    longint      acc;
    logic [63:0] bits;
    int          r, len, n, sh;
    r = 1 << sel;
    len = 1;
    for (int i = 0; i < 64; i++) h[i] = 0;
    h[0] = 1;
    for (int s = 0; s < N; s++) begin
      for (int i = 0; i < 64; i++) t[i] = 0;
      for (int i = 0; i < len; i++)
        for (int j = 0; j < r; j++) t[i+j] += h[i];
      len = len + r - 1;
      h = t;
    end
    n = hist.size();
    acc = 0;
    for (int j = 0; j < len && j < n; j++) acc += h[j] * hist[n-1-j];
    sh = N * sel;
    if (sh > 0) acc = (acc + (longint'(1) << (sh - 1))) >>> sh;
    bits = acc;
    return bits[15:0];
  endfunction

  // Drive one cycle, advance the reference model, then check after the edge.
  task automatic step(input logic r, input logic v, input logic [15:0] x,
                      input logic byp, input logic [2:0] ds);
    logic [2:0]  cl;
    logic        exp_valid;
    logic        exp_busy;
    logic [15:0] e;
    rst = r;
    bus.valid_in = v;
    bus.cic_in = x;
    bus.bypass = byp;
    bus.dec_sel = ds;
    cl = (ds > 3'd4) ? 3'd4 : ds;
    exp_valid = 1'b0;
    if (r) begin
      hist.delete();
      exp_q.delete();
      m_out = 16'h0000;
      m_flush = 1'b0;
      m_dec = cl;
    end else if (byp) begin
      hist.delete();
      m_dec = cl;
      m_flush = 1'b0;
      m_out = x;
      exp_valid = v;
      if (v) exp_q.push_back(x);
    end else if (m_flush) begin
      hist.delete();
      m_dec = cl;
      m_flush = 1'b0;
    end else if (cl != m_dec) begin
      m_flush = 1'b1;
    end else if (v) begin
      hist.push_back(longint'($signed(x)));
      if (hist.size() % (1 << m_dec) == 0) begin
        e = cic_ref(int'(m_dec));
        exp_q.push_back(e);
        m_out = e;
        exp_valid = 1'b1;
      end
    end
    exp_busy = m_flush;

    @(posedge clk);
    #1;
    n_checks++;
    assert (bus.valid_out === exp_valid) else begin
      n_errors++;
      $error("FAIL valid_out: got %b expected %b", bus.valid_out, exp_valid);
    end
    n_checks++;
    assert (bus.busy === exp_busy) else begin
      n_errors++;
      $error("FAIL busy: got %b expected %b", bus.busy, exp_busy);
    end
    if (bus.valid_out === 1'b1) begin
      n_checks++;
      assert (exp_q.size() != 0) else begin
        n_errors++;
        $error("FAIL scoreboard_empty: got output %h expected none", bus.cic_out);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_checks++;
        assert (bus.cic_out === e) else begin
          n_errors++;
          $error("FAIL cic_out: got %h expected %h", bus.cic_out, e);
        end
      end
    end else begin
      n_checks++;
      assert (bus.cic_out === m_out) else begin
        n_errors++;
        $error("FAIL cic_out_hold: got %h expected %h", bus.cic_out, m_out);
      end
    end
  endtask

  task automatic do_reset(input logic [2:0] ds);
    for (int i = 0; i < 2; i++)
      step(1'b1, 1'($urandom), 16'($urandom), 1'($urandom), ds);
  endtask

  initial begin
    rst = 1'b1;
    bus.valid_in = 1'b0;
    bus.bypass = 1'b0;
    bus.dec_sel = 3'd2;
    bus.cic_in = 16'h0000;
    m_out = 16'h0000;
    m_dec = 3'd2;
    m_flush = 1'b0;

    // Reset with random inputs, then DC 0x4000 at R=4.
    do_reset(3'd2);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 16'h4000, 1'b0, 3'd2);

    // DC full-scale negative: no wrap error in the accumulators.
    do_reset(3'd2);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 16'h8000, 1'b0, 3'd2);

    // Impulses at R=2: 0x0800 -> 0x0300, 0x0100, 0x0000; 0x0004 -> 0x0002, 0x0001.
    do_reset(3'd1);
    step(1'b0, 1'b1, 16'h0800, 1'b0, 3'd1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 16'h0000, 1'b0, 3'd1);
    do_reset(3'd1);
    step(1'b0, 1'b1, 16'h0004, 1'b0, 3'd1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 16'h0000, 1'b0, 3'd1);

    // R=1 passthrough with valid_in gaps.
    do_reset(3'd0);
    for (int i = 0; i < 40; i++) step(1'b0, 1'($urandom), 16'($urandom), 1'b0, 3'd0);

    // Random stream at R=4 with gaps.
    do_reset(3'd2);
    for (int i = 0; i < 40; i++) step(1'b0, 1'($urandom_range(0, 3) != 0), 16'($urandom), 1'b0, 3'd2);

    // Rate change mid-period 2 -> 3, then 3 -> 7 (clamped to 4).
    do_reset(3'd2);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 16'($urandom), 1'b0, 3'd2);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 16'($urandom), 1'b0, 3'd3);
    for (int i = 0; i < 36; i++) step(1'b0, 1'b1, 16'($urandom), 1'b0, 3'd7);
    // 7 and 4 clamp to the same rate: no flush expected.
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 16'($urandom), 1'b0, 3'd4);

    // Bypass in mid-period, exit restarts from zero state, then reset mid-bypass.
    do_reset(3'd2);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'($urandom), 1'b0, 3'd2);
    for (int i = 0; i < 6; i++) step(1'b0, 1'($urandom), 16'($urandom), 1'b1, 3'd2);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 16'($urandom), 1'b0, 3'd2);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'($urandom), 1'b1, 3'd2);
    step(1'b1, 1'b1, 16'h7FFF, 1'b1, 3'd2);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 16'h1234, 1'b0, 3'd2);

    n_checks++;
    assert (exp_q.size() == 0) else begin
      n_errors++;
      $error("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
